// File: rtl/ls_pkg.sv
//==============================================================================
// Module  : ls_pkg
// Brief   : Shared mode/state encodings for the life-support controller.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

package ls_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 2'd0,
    MODE_UP    = 2'd1,
    MODE_DOWN  = 2'd2,
    MODE_TRACK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ls_sat_channel.sv
//==============================================================================
// Module  : ls_sat_channel
// Brief   : One saturating channel: load, mode step, drain, optional alarm
//           (alarm logic present only when LS_ALARM_EN is defined).
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module ls_sat_channel
  import ls_pkg::*;
#(
  parameter int W    = 5,
  parameter int HYST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [W-1:0]      ld_val,
  input  logic [MODE_W-1:0] mode,
  input  logic [W-1:0]      target,
  input  logic [W-1:0]      thr,
  input  logic              step_en,
  input  logic              drain_en,
  output logic [W-1:0]      value,
  output logic              at_max,
  output logic              at_min,
  output logic              alarm
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (ld) begin
      value_d = ld_val;
    end else if (drain_en) begin
      if (value_q != '0) value_d = value_q - ONE;
    end else if (step_en) begin
      case (mode_e'(mode))
        MODE_UP:    if (value_q != '1) value_d = value_q + ONE;
        MODE_DOWN:  if (value_q != '0) value_d = value_q - ONE;
        MODE_TRACK: begin
          if (value_q < target)      value_d = value_q + ONE;
          else if (value_q > target) value_d = value_q - ONE;
        end
        default:    value_d = value_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value  = value_q;
  assign at_max = (value_q == '1);
  assign at_min = (value_q == '0);

`ifdef LS_ALARM_EN
  localparam logic [W:0] HYST_E = (W+1)'(HYST);

  logic       alarm_q, alarm_d;
  logic [W:0] thr_lo;

  // Clear level is thr-HYST floored at zero; extra bit avoids underflow.
  always_comb begin
    thr_lo  = ({1'b0, thr} > HYST_E) ? ({1'b0, thr} - HYST_E) : '0;
    alarm_d = alarm_q;
    if (value_q >= thr)                alarm_d = 1'b1;
    else if ({1'b0, value_q} < thr_lo) alarm_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alarm_q <= 1'b0;
    else      alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  logic unused_thr;
  assign unused_thr = ^thr;
  assign alarm      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/life_support_ctrl.sv
//==============================================================================
// Module  : life_support_ctrl
// Brief   : Power FSM + step prescaler driving NCH saturating channels.
//           Define LS_ALARM_EN to include the per-channel alarm logic.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module life_support_ctrl
  import ls_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int W    = 5,
  parameter int DIV  = 1,
  parameter int HYST = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwr,
  input  logic [NCH-1:0]        ld,
  input  logic [NCH*W-1:0]      ld_val,
  input  logic [NCH*MODE_W-1:0] mode,
  input  logic [NCH*W-1:0]      target,
  input  logic [W-1:0]          thr,
  output logic [NCH*W-1:0]      value,
  output logic [NCH-1:0]        at_max,
  output logic [NCH-1:0]        at_min,
  output logic [NCH-1:0]        alarm,
  output logic [1:0]            state
);

  localparam logic [7:0] PRE_LAST = 8'(DIV - 1);

  logic [7:0] pre_q, pre_d;
  logic       tick;
  state_e     state_q, state_d;
  logic       any_nz;
  logic       step_en;
  logic       drain_en;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? 8'd0 : pre_q + 8'd1;
  end

  assign any_nz = |value;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (pwr)         state_d = ST_RUN;
        else if (any_nz) state_d = ST_DRAIN;
      end
      ST_RUN: begin
        if (!pwr) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pwr)                  state_d = ST_RUN;
        else if (!any_nz && tick) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= 8'd0;
      state_q <= ST_OFF;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
    end
  end

  assign step_en  = tick && (state_q == ST_RUN);
  assign drain_en = tick && (state_q == ST_DRAIN);
  assign state    = state_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ls_sat_channel #(
      .W    (W),
      .HYST (HYST)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld[i]),
      .ld_val   (ld_val[i*W +: W]),
      .mode     (mode[i*MODE_W +: MODE_W]),
      .target   (target[i*W +: W]),
      .thr      (thr),
      .step_en  (step_en),
      .drain_en (drain_en),
      .value    (value[i*W +: W]),
      .at_max   (at_max[i]),
      .at_min   (at_min[i]),
      .alarm    (alarm[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_life_support_ctrl.sv
//==============================================================================
// Module  : tb_life_support_ctrl
// Brief   : Scoreboard bench for life_support_ctrl (DIV=1 and DIV=4 builds).
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module tb_life_support_ctrl;

  localparam int W = 5;

  localparam int S_V0  = 0;
  localparam int S_V1  = 1;
  localparam int S_ST  = 2;
  localparam int S_MAX = 3;
  localparam int S_MIN = 4;
  localparam int S_ALM = 5;
  localparam int S_V4  = 6;
  localparam int S_ST4 = 7;

  logic       clk;
  logic       rst;
  logic       pwr;
  logic [1:0] ld;
  logic [9:0] ld_val;
  logic [3:0] mode;
  logic [9:0] target;
  logic [4:0] thr;
  logic [9:0] value;
  logic [1:0] at_max, at_min, alarm;
  logic [1:0] state;

  logic       pwr4;
  logic [1:0] ld4;
  logic [9:0] ld_val4;
  logic [3:0] mode4;
  logic [9:0] target4;
  logic [9:0] value4;
  logic [1:0] at_max4, at_min4, alarm4;
  logic [1:0] state4;

  life_support_ctrl #(.NCH(2), .W(W), .DIV(1), .HYST(2)) dut (
    .clk(clk), .rst(rst), .pwr(pwr), .ld(ld), .ld_val(ld_val), .mode(mode),
    .target(target), .thr(thr), .value(value), .at_max(at_max),
    .at_min(at_min), .alarm(alarm), .state(state)
  );

  life_support_ctrl #(.NCH(2), .W(W), .DIV(4), .HYST(2)) dut4 (
    .clk(clk), .rst(rst), .pwr(pwr4), .ld(ld4), .ld_val(ld_val4), .mode(mode4),
    .target(target4), .thr(thr), .value(value4), .at_max(at_max4),
    .at_min(at_min4), .alarm(alarm4), .state(state4)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] alm(input logic [1:0] a);
`ifdef LS_ALARM_EN
    return a;
`else
    return 2'b00 & a;
`endif
  endfunction

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_V0:    return 32'(value[4:0]);
      S_V1:    return 32'(value[9:5]);
      S_ST:    return 32'(state);
      S_MAX:   return 32'(at_max);
      S_MIN:   return 32'(at_min);
      S_ALM:   return 32'(alarm);
      S_V4:    return 32'(value4[4:0]);
      S_ST4:   return 32'(state4);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  task automatic push(input string name, input int sel, input logic [31:0] want);
    exp_t e;
    e.tag = $sformatf("%s@%0d", name, cyc);
    e.sel = sel;
    e.exp = want;
    sb.push_back(e);
  endtask

  task automatic flush();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    flush();
  endtask

  initial begin
    int v0_seq[4];
    int v1_seq[5];
    int up_v[3];
    int up_a[3];
    int dn_v[5];
    int dn_a[5];
    int dr0[6];
    int dr1[6];
    int drs[6];
    int e4;

    v0_seq = '{30, 31, 31, 31};
    v1_seq = '{13, 12, 11, 10, 10};
    up_v   = '{19, 20, 21};
    up_a   = '{0, 0, 1};
    dn_v   = '{20, 19, 18, 17, 16};
    dn_a   = '{1, 1, 1, 1, 0};
    dr0    = '{3, 2, 1, 0, 0, 0};
    dr1    = '{1, 0, 0, 0, 0, 0};
    drs    = '{2, 2, 2, 2, 0, 0};

    rst = 1'b0; pwr = 1'b0; ld = '0; ld_val = '0; mode = '0; target = '0; thr = 5'd20;
    pwr4 = 1'b0; ld4 = '0; ld_val4 = '0; mode4 = '0; target4 = '0;

    #12;
    push("rst_v0", S_V0, 0);  push("rst_v1", S_V1, 0);
    push("rst_st", S_ST, 0);  push("rst_alm", S_ALM, 0);
    push("rst_min", S_MIN, 3); push("rst_max", S_MAX, 0);
    flush();
    rst = 1'b1;

    // Async reset mid-operation, observed before the next edge
    pwr = 1'b1; ld = 2'b01; ld_val[4:0] = 5'd7;
    push("ld7_v0", S_V0, 7); push("ld7_st", S_ST, 1);
    step();
    ld = 2'b00;
    #3 rst = 1'b0;
    #1;
    push("arst_v0", S_V0, 0); push("arst_st", S_ST, 0); push("arst_alm", S_ALM, 0);
    flush();
    #2 rst = 1'b1;

    // UP saturation at all-ones
    mode[1:0] = 2'd1; ld = 2'b01; ld_val[4:0] = 5'd29;
    push("up_v0", S_V0, 29); push("up_max", S_MAX, 0);
    step();
    ld = 2'b00;
    for (int i = 0; i < 4; i++) begin
      push("up_v0", S_V0, 32'(v0_seq[i]));
      push("up_max", S_MAX, (v0_seq[i] == 31) ? 1 : 0);
      push("up_v1", S_V1, 0);
      push("up_st", S_ST, 1);
      step();
    end

    // TRACK toward target, ch0 held
    mode[1:0] = 2'd0; mode[3:2] = 2'd3; target[9:5] = 5'd10;
    ld = 2'b10; ld_val[9:5] = 5'd14;
    push("trk_v1", S_V1, 14); push("trk_v0", S_V0, 31);
    step();
    ld = 2'b00;
    for (int i = 0; i < 5; i++) begin
      push("trk_v1", S_V1, 32'(v1_seq[i]));
      push("trk_v0", S_V0, 31);
      step();
    end
    target[9:5] = 5'd12;
    for (int i = 11; i <= 13; i++) begin
      push("trku_v1", S_V1, (i > 12) ? 12 : 32'(i));
      step();
    end

    // Alarm set at threshold, clear below threshold-hysteresis
    ld = 2'b01; ld_val[4:0] = 5'd0;
    push("al_v0", S_V0, 0); push("al_a", S_ALM, 32'(alm(2'b01)));
    step();
    ld = 2'b00;
    push("al_v0", S_V0, 0); push("al_a", S_ALM, 0);
    step();
    ld = 2'b01; ld_val[4:0] = 5'd18; mode[1:0] = 2'd1;
    push("al_v0", S_V0, 18); push("al_a", S_ALM, 0);
    step();
    ld = 2'b00;
    for (int i = 0; i < 3; i++) begin
      push("alu_v0", S_V0, 32'(up_v[i]));
      push("alu_a", S_ALM, 32'(alm(2'(up_a[i]))));
      step();
    end
    mode[1:0] = 2'd2;
    for (int i = 0; i < 5; i++) begin
      push("ald_v0", S_V0, 32'(dn_v[i]));
      push("ald_a", S_ALM, 32'(alm(2'(dn_a[i]))));
      step();
    end

    // Simultaneous loads, then drain to OFF
    mode = '0; ld = 2'b11; ld_val = {5'd1, 5'd3};
    push("sim_v0", S_V0, 3); push("sim_v1", S_V1, 1);
    step();
    ld = 2'b00; pwr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push("dr_v0", S_V0, 32'(dr0[i]));
      push("dr_v1", S_V1, 32'(dr1[i]));
      push("dr_st", S_ST, 32'(drs[i]));
      step();
    end

    // Load while OFF forces a drain pass
    ld = 2'b10; ld_val[9:5] = 5'd2;
    push("od_v1", S_V1, 2); push("od_st", S_ST, 0);
    step();
    ld = 2'b00;
    push("od_v1", S_V1, 2); push("od_st", S_ST, 2); step();
    push("od_v1", S_V1, 1); push("od_st", S_ST, 2); step();
    push("od_v1", S_V1, 0); push("od_st", S_ST, 2); step();
    push("od_v1", S_V1, 0); push("od_st", S_ST, 0); step();

    // DOWN saturates at zero
    pwr = 1'b1; mode[1:0] = 2'd2;
    push("dn0_st", S_ST, 1); push("dn0_v0", S_V0, 0); step();
    push("dn0_v0", S_V0, 0); push("dn0_min", S_MIN, 3); step();

    // Prescaled instance: reset mid-cycle to align, then step every 4th edge
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    pwr4 = 1'b1; mode4[1:0] = 2'd1;
    e4 = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 10) begin
        ld4 = 2'b01; ld_val4[4:0] = 5'd9;
        e4 = 9;
      end else begin
        ld4 = 2'b00;
        if ((k % 4 == 0) && (e4 != 31)) e4 = e4 + 1;
      end
      push("d4_v0", S_V4, 32'(e4));
      step();
    end
    push("d4_st", S_ST4, 1);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/life_support_ctrl.md
LIFE_SUPPORT_CTRL -- requirements
Module: life_support_ctrl

Interface
REQ-001 The block SHALL have parameter NCH, default 2, giving the number of independent channels (ch0 = shield, ch1 = temperature).
REQ-002 The block SHALL have parameter W, default 5, giving the per-channel counter width.
REQ-003 The block SHALL have parameter DIV, default 1, giving clock cycles per step tick (range 1..255).
REQ-004 The block SHALL have parameter HYST, default 2, giving the alarm-clear hysteresis in counts.
REQ-005 Port clk, input, 1 bit: the single clock, rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port pwr, input, 1 bit: system power enable.
REQ-008 Port ld, input, NCH bits: per-channel load strobe.
REQ-009 Port ld_val, input, NCH*W bits: per-channel load value, ch i at [i*W +: W].
REQ-010 Port mode, input, NCH*2 bits: per-channel mode (HOLD=0, UP=1, DOWN=2, TRACK=3).
REQ-011 Port target, input, NCH*W bits: per-channel TRACK target.
REQ-012 Port thr, input, W bits: alarm threshold common to all channels.
REQ-013 Port value, output, NCH*W bits: registered channel values.
REQ-014 Port at_max / at_min, output, NCH bits each: value equals all-ones / zero.
REQ-015 Port alarm, output, NCH bits: registered over-threshold flag.
REQ-016 Port state, output, 2 bits: system state (OFF=0, RUN=1, DRAIN=2).

Function
REQ-017 The prescaler SHALL count 0..DIV-1 and assert tick in the cycle its count equals DIV-1; with DIV=1, tick SHALL be asserted every cycle.
REQ-018 The prescaler SHALL count in every state and restart from 0 on reset only.
REQ-019 FSM transitions SHALL be: OFF->RUN when pwr=1; RUN->DRAIN when pwr=0; DRAIN->RUN when pwr=1; DRAIN->OFF when pwr=0 and all values are zero at a tick edge; OFF->DRAIN when pwr=0 and any value is nonzero.
REQ-020 Per-channel update priority SHALL be: reset > ld[i] > state/mode step.
REQ-021 ld[i]=1 SHALL set value[i]=ld_val[i] at the next edge, independent of tick and state.
REQ-022 In RUN on tick: HOLD SHALL keep the value; UP SHALL add +1; DOWN SHALL add -1; TRACK SHALL step 1 toward target[i] and hold when equal.
REQ-023 In DRAIN on tick, every nonzero channel SHALL decrement by 1, regardless of mode.
REQ-024 In OFF, values SHALL hold.
REQ-025 Arithmetic SHALL saturate without wrap: UP at all-ones holds; DOWN or DRAIN at 0 holds.
REQ-026 at_max and at_min SHALL be combinational decodes of the registered value.
REQ-027 alarm[i] SHALL set at the edge after value[i] >= thr.
REQ-028 alarm[i] SHALL clear at the edge after value[i] < thr-HYST, where thr-HYST saturates at 0; otherwise alarm[i] SHALL hold.
REQ-029 Channels SHALL be fully independent; simultaneous ld on several channels SHALL all take effect in the same cycle.

Reset
REQ-030 On rst=0, the block SHALL immediately force value=0, alarm=0, state=OFF and prescaler=0, asynchronously and regardless of clk.
REQ-031 Reset assertion mid-load or mid-drain SHALL discard the operation; after release, the first update SHALL occur at the first rising edge.

Configuration
REQ-032 With macro LS_ALARM_EN defined, the alarm logic SHALL be present per REQ-027/028.
REQ-033 Without LS_ALARM_EN, the alarm port SHALL remain but be tied to 0, and the thr input SHALL be unused.

Structure
REQ-034 Package ls_pkg SHALL hold the mode encodings, the state encodings and the mode field width 2.
REQ-035 Sub-module ls_sat_channel SHALL implement one channel (load, saturating step, TRACK compare, alarm) and be instantiated NCH times.
REQ-036 The FSM and prescaler SHALL reside in the top level.

Verification (W=5, DIV=1, HYST=2, thr=20 unless noted)
REQ-037 Drive rst=0 mid-count with value=7 -> value=0, state=OFF, alarm=0 asynchronously, before the next edge.
REQ-038 Apply pwr=1, mode0=UP, ld0 with ld_val=29 -> value0 sequence 29,30,31,31,31 with at_max0=1 from 31.
REQ-039 Set ch1 mode=TRACK, target=10 from value 14 -> value1 sequence 13,12,11,10,10; ch0 unaffected.
REQ-040 Drop pwr to 0 with values 3 and 1 -> state=DRAIN, values step to (2,0),(1,0),(0,0), then state=OFF.
REQ-041 With LS_ALARM_EN, ch0 UP from 18 -> alarm0 rises the edge after value=20; switching to DOWN clears alarm0 only the edge after value=17.
REQ-042 Set DIV=4 with UP from 0 and assert ld0 (ld_val=9) between ticks -> value0 steps once per 4 cycles, and the load takes effect the next edge without waiting for a tick.
